// File: rtl/cgra_obi_mem_responder.sv
// ---------------------------------------------------------------------------
// cgra_obi_mem_responder
//
// Memory-side OBI responder terminating one CGRA column master port. Requests
// are granted while fewer than FIFO_DEPTH transactions are outstanding. Reads
// return a word from an internal array. Writes update the byte lanes selected
// by be_i and return zero. Every response passes through a LATENCY-stage delay
// line and then a response FIFO. The FIFO can be frozen with rsp_stall_i to
// apply grant back-pressure to the master.
//
// Ports
//   clk_i          clock
//   rst_i          asynchronous reset, active-high
//   req_i          OBI request
//   addr_i         byte address (bits [1:0] ignored)
//   we_i           1 = write
//   be_i           byte enables (writes only)
//   wdata_i        write data
//   gnt_o          OBI grant (combinational)
//   rvalid_o       response valid
//   rdata_o        response data (holds its last value while rvalid_o=0)
//   gnt_stall_i    test control: force gnt_o low
//   rsp_stall_i    test control: hold responses in the FIFO
//   outstanding_o  transactions granted but not yet responded
// ---------------------------------------------------------------------------
module cgra_obi_mem_responder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_WORDS  = 1024,
  parameter int                    LATENCY    = 1,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               req_i,
  input  logic [ADDR_WIDTH-1:0]              addr_i,
  input  logic                               we_i,
  input  logic [3:0]                         be_i,
  input  logic [DATA_WIDTH-1:0]              wdata_i,
  output logic                               gnt_o,
  output logic                               rvalid_o,
  output logic [DATA_WIDTH-1:0]              rdata_o,
  input  logic                               gnt_stall_i,
  input  logic                               rsp_stall_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    outstanding_o
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // -------------------------------------------------------------------------
  // Grant and address decode
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] outstanding_reg;
  logic             hs;
  logic [IDX_W-1:0] word_idx;
  logic             in_range;
  logic             unused_addr_lsb;

  // The occupancy term uses the registered count only, so a slot freed by a
  // pop becomes grantable one cycle later and gnt_o never depends on rvalid_o.
  assign gnt_o = req_i & ~gnt_stall_i & ~rst_i &
                 (outstanding_reg < CNT_W'(FIFO_DEPTH));
  assign hs    = gnt_o;

  assign word_idx        = addr_i[IDX_W+1:2];
  assign unused_addr_lsb = ^addr_i[1:0];

  generate
    if (ADDR_WIDTH - 2 > IDX_W) begin : g_range_check
      assign in_range = ~|addr_i[ADDR_WIDTH-1:IDX_W+2];
    end else begin : g_no_range_check
      assign in_range = 1'b1;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Word array: byte-lane writes, registered read at the handshake edge.
  // A read sees every write handshaked on an earlier edge.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
  logic [DATA_WIDTH-1:0] rd_data_reg;

  always_ff @(posedge clk_i) begin
    if (hs && in_range) begin
      if (we_i) begin
        for (int k = 0; k < 4; k++) begin
          if (be_i[k]) begin
            mem[word_idx][k*8 +: 8] <= wdata_i[k*8 +: 8];
          end
        end
      end else begin
        rd_data_reg <= mem[word_idx];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Response delay line. Stage 0 is the RAM read register plus the response
  // kind; later stages carry the already-resolved response word.
  // -------------------------------------------------------------------------
  logic                  s0_valid_reg;
  logic                  s0_we_reg;
  logic                  s0_oor_reg;
  logic [LATENCY-1:0]    pipe_valid;
  logic [DATA_WIDTH-1:0] pipe_data [LATENCY];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s0_valid_reg <= 1'b0;
      s0_we_reg    <= 1'b0;
      s0_oor_reg   <= 1'b0;
    end else begin
      s0_valid_reg <= hs;
      if (hs) begin
        s0_we_reg  <= we_i;
        s0_oor_reg <= ~in_range;
      end
    end
  end

  assign pipe_valid[0] = s0_valid_reg;
  assign pipe_data[0]  = s0_we_reg  ? '0 :
                         s0_oor_reg ? ERR_DATA : rd_data_reg;

  genvar gi;
  generate
    for (gi = 1; gi < LATENCY; gi++) begin : g_stage
      logic                  v_reg;
      logic [DATA_WIDTH-1:0] d_reg;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          v_reg <= 1'b0;
          d_reg <= '0;
        end else begin
          v_reg <= pipe_valid[gi-1];
          d_reg <= pipe_data[gi-1];
        end
      end

      assign pipe_valid[gi] = v_reg;
      assign pipe_data[gi]  = d_reg;
    end
  endgenerate

  logic                  last_valid;
  logic [DATA_WIDTH-1:0] last_data;

  assign last_valid = pipe_valid[LATENCY-1];
  assign last_data  = pipe_data[LATENCY-1];

  // -------------------------------------------------------------------------
  // Response FIFO with bypass: when the FIFO is empty the last pipeline stage
  // is presented directly, so an unstalled response appears exactly LATENCY
  // cycles after its handshake. No internal back-pressure is needed because
  // the grant limit bounds pipeline + FIFO occupancy to FIFO_DEPTH.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      fifo_count_reg;
  logic                  fifo_empty;
  logic                  pop;
  logic                  fifo_pop;
  logic                  push;
  logic [DATA_WIDTH-1:0] head_data;
  logic [DATA_WIDTH-1:0] rdata_hold_reg;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty = (fifo_count_reg == '0);
  assign rvalid_o   = (~fifo_empty | last_valid) & ~rsp_stall_i;
  assign head_data  = fifo_empty ? last_data : fifo_mem[rd_ptr_reg];
  assign pop        = rvalid_o;
  assign fifo_pop   = pop & ~fifo_empty;
  // The last stage bypasses the FIFO only when it is the head being popped.
  assign push       = last_valid & ~(pop & fifo_empty);
  assign rdata_o    = rvalid_o ? head_data : rdata_hold_reg;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= last_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      fifo_count_reg  <= '0;
      outstanding_reg <= '0;
      rdata_hold_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (fifo_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      if (pop) begin
        rdata_hold_reg <= head_data;
      end
      fifo_count_reg  <= fifo_count_reg + CNT_W'(push) - CNT_W'(fifo_pop);
      outstanding_reg <= outstanding_reg + CNT_W'(hs) - CNT_W'(pop);
    end
  end

  assign outstanding_o = outstanding_reg;

  // -------------------------------------------------------------------------
  // Consistency checks
  // -------------------------------------------------------------------------
  int pipe_count;

  always_comb begin
    pipe_count = 0;
    for (int i = 0; i < LATENCY; i++) begin
      pipe_count = pipe_count + int'(pipe_valid[i]);
    end
  end

  a_occupancy: assert property (@(posedge clk_i) disable iff (rst_i)
    int'(outstanding_reg) == pipe_count + int'(fifo_count_reg));

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && fifo_count_reg == CNT_W'(FIFO_DEPTH)));

  a_no_rvalid_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    (outstanding_reg == '0) |-> !rvalid_o);

endmodule

// File: tb/tb_cgra_obi_mem_responder.sv
module tb_cgra_obi_mem_responder;

  localparam int          LAT   = 3;
  localparam int          DEPTH = 4;
  localparam int          NW    = 1024;
  localparam int          OW    = $clog2(DEPTH + 1);
  localparam logic [31:0] ERR   = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic          gnt_stall = 1'b0;
  logic          rsp_stall = 1'b0;
  logic [31:0]   addr = '0;
  logic [31:0]   wdata = '0;
  logic [3:0]    be = '0;
  logic          gnt;
  logic          rvalid;
  logic [31:0]   rdata;
  logic [OW-1:0] outstanding;

  always #5 clk = ~clk;

  cgra_obi_mem_responder #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NUM_WORDS  (NW),
    .LATENCY    (LAT),
    .FIFO_DEPTH (DEPTH),
    .ERR_DATA   (ERR)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_i         (req),
    .addr_i        (addr),
    .we_i          (we),
    .be_i          (be),
    .wdata_i       (wdata),
    .gnt_o         (gnt),
    .rvalid_o      (rvalid),
    .rdata_o       (rdata),
    .gnt_stall_i   (gnt_stall),
    .rsp_stall_i   (rsp_stall),
    .outstanding_o (outstanding)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: a queue of pending responses, each with the cycle at
  // which it becomes deliverable. Responses leave strictly in order, one per
  // unstalled cycle. Memory is a plain word array.
  // -------------------------------------------------------------------------
  typedef struct {
    logic [31:0] data;
    int          ready;
  } rsp_t;

  rsp_t        q[$];
  logic [31:0] mdl_mem [NW];
  int          cyc = 0;
  int          hs_cnt = 0;
  int          rsp_cnt = 0;
  logic [31:0] last_rsp = '0;

  int          m_n;
  logic        m_gnt;
  logic        m_rv;
  int          m_idx;
  rsp_t        m_r;

  initial begin
    for (int i = 0; i < NW; i++) mdl_mem[i] = '0;
  end

  always @(negedge clk) begin
    if (rst) begin
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_outstanding", 32'(outstanding), 32'd0);
      q.delete();
    end else begin
      m_n = q.size();
      check("outstanding", 32'(outstanding), 32'(m_n));
      m_gnt = req && !gnt_stall && (m_n < DEPTH);
      check("gnt", 32'(gnt), 32'(m_gnt));
      m_rv = (m_n > 0) && (q[0].ready <= cyc) && !rsp_stall;
      check("rvalid", 32'(rvalid), 32'(m_rv));
      if (rvalid) begin
        rsp_cnt++;
        last_rsp = rdata;
      end
      if (m_rv && rvalid) begin
        check("rdata", rdata, q[0].data);
        $display("rsp cyc=%0d data=%h exp=%h", cyc, rdata, q[0].data);
      end
      if (m_rv) void'(q.pop_front());
      if (m_gnt) begin
        hs_cnt++;
        m_idx = (addr[31:2] < NW) ? int'(addr[31:2]) : -1;
        m_r.ready = cyc + LAT;
        if (we) m_r.data = '0;
        else if (m_idx < 0) m_r.data = ERR;
        else m_r.data = mdl_mem[m_idx];
        q.push_back(m_r);
        if (we && m_idx >= 0) begin
          for (int k = 0; k < 4; k++) begin
            if (be[k]) mdl_mem[m_idx][k*8 +: 8] = wdata[k*8 +: 8];
          end
        end
      end
    end
    cyc++;
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers. Inputs change 1 time unit after the rising edge.
  // -------------------------------------------------------------------------
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b);
    logic g;
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      g = gnt;
      @(posedge clk);
      #1;
      if (g) return;
    end
    check("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    req = 1'b0; we = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    idle();
    rsp_stall = 1'b0;
    gnt_stall = 1'b0;
    t = 0;
    while (q.size() != 0 && t < 60) begin
      wait_cycles(1);
      t++;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
    wait_cycles(2);
  endtask

  logic [31:0] word0_val;
  int          h0;
  int          c0;
  int          r0;
  logic [31:0] ra;

  initial begin
    wait_cycles(3);
    rst = 1'b0;
    #1;
    check("reset_rdata", rdata, 32'd0);
    check("reset_rvalid", 32'(rvalid), 32'd0);
    check("reset_outstanding", 32'(outstanding), 32'd0);

    // Preload words 0..63 so every later read hits known data.
    word0_val = $urandom;
    xact(1'b1, 32'h0, word0_val, 4'hF);
    for (int i = 1; i < 64; i++) xact(1'b1, 32'(i * 4), $urandom, 4'hF);
    drain();

    // Basic write then read.
    xact(1'b1, 32'h40, 32'h1234_5678, 4'hF);
    xact(1'b0, 32'h40, 32'h0, 4'h0);
    drain();
    check("t1_read", last_rsp, 32'h1234_5678);

    // Byte-enable merge.
    xact(1'b1, 32'h44, 32'hFFFF_FFFF, 4'hF);
    xact(1'b1, 32'h44, 32'h0000_00AA, 4'b0001);
    xact(1'b0, 32'h44, 32'h0, 4'hF);
    drain();
    check("t2_byte", last_rsp, 32'hFFFF_FFAA);

    // Back-to-back reads: one grant per cycle.
    c0 = cyc;
    r0 = rsp_cnt;
    for (int i = 0; i < 16; i++) xact(1'b0, 32'(i * 4), 32'h0, 4'h0);
    check("t3_cycles", 32'(cyc - c0), 32'd16);
    drain();
    check("t3_rsp_count", 32'(rsp_cnt - r0), 32'd16);

    // Back-pressure via response stall.
    rsp_stall = 1'b1;
    h0 = hs_cnt;
    req = 1'b1; we = 1'b0; addr = 32'h8; be = 4'h0;
    wait_cycles(8);
    check("t4_grants", 32'(hs_cnt - h0), 32'd4);
    check("t4_outstanding", 32'(outstanding), 32'd4);
    check("t4_gnt_low", 32'(gnt), 32'd0);
    rsp_stall = 1'b0;
    wait_cycles(6);
    drain();

    // Out-of-range accesses.
    xact(1'b0, 32'h1000, 32'h0, 4'hF);
    drain();
    check("t5_err", last_rsp, ERR);
    xact(1'b1, 32'h1000, 32'h5555_5555, 4'hF);
    xact(1'b0, 32'h0, 32'h0, 4'hF);
    drain();
    check("t5_word0", last_rsp, word0_val);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      req       = ($urandom_range(0, 3) != 0);
      we        = $urandom_range(0, 1);
      be        = 4'($urandom);
      wdata     = $urandom;
      gnt_stall = ($urandom_range(0, 9) == 0);
      rsp_stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) begin
        ra = 32'h1000 + 32'($urandom_range(0, 100000)) * 4;
      end else begin
        ra = 32'($urandom_range(0, 63)) * 4;
      end
      addr = ra | 32'($urandom_range(0, 3));
      wait_cycles(1);
    end
    drain();

    // Reset with responses in flight.
    rsp_stall = 1'b1;
    for (int i = 0; i < 3; i++) xact(1'b0, 32'(i * 4), 32'h0, 4'h0);
    idle();
    wait_cycles(4);
    check("t6_outstanding_pre", 32'(outstanding), 32'd3);
    r0 = rsp_cnt;
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    rsp_stall = 1'b0;
    wait_cycles(6);
    check("t6_no_rvalid", 32'(rsp_cnt - r0), 32'd0);
    check("t6_outstanding", 32'(outstanding), 32'd0);
    xact(1'b0, 32'h40, 32'h0, 4'h0);
    drain();
    check("t6_rsp_count", 32'(rsp_cnt - r0), 32'd1);
    check("t6_read", last_rsp, mdl_mem[16]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
